// File: rtl/fios_opsrv_pkg.sv
// Shared types and constants for the FIOS operand/result server.
package fios_opsrv_pkg;
  localparam int WORD_W = 17;

  localparam logic [1:0] SEL_A = 2'd0;
  localparam logic [1:0] SEL_B = 2'd1;
  localparam logic [1:0] SEL_P = 2'd2;

  typedef enum logic [1:0] {IDLE, START, RUN, DONE} opsrv_state_t;
endpackage

// File: rtl/fios_opsrv_wbuf.sv
// s x WORD_W word buffer: one write port, one registered read port with enable.
module fios_opsrv_wbuf
  import fios_opsrv_pkg::*;
#(
  parameter int s  = 8,
  parameter int AW = $clog2(s)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_wr_en,
  input  logic [AW-1:0]     i_wr_addr,
  input  logic [WORD_W-1:0] i_wr_data,
  input  logic              i_rd_en,
  input  logic [AW-1:0]     i_rd_addr,
  output logic [WORD_W-1:0] o_rd_data
);
  logic [WORD_W-1:0] r_mem [s];
  logic [WORD_W-1:0] r_rd_data;

  always_ff @(posedge i_clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)     r_rd_data <= '0;
    else if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;
endmodule

// File: rtl/fios_operand_server.sv
// Serves A window, B/P word streams and captures RES words for the FIOS core.
// Optional protocol checking (err_o) enabled by FIOS_OPSRV_PROTO_CHECK_EN.
module fios_operand_server
  import fios_opsrv_pkg::*;
#(
  parameter int s     = 8,
  parameter int PE_NB = 8,
  localparam int AW   = $clog2(s)
) (
  input  logic                    clock_i,
  input  logic                    reset_n_i,
  input  logic                    wr_en_i,
  input  logic [1:0]              wr_sel_i,
  input  logic [AW-1:0]           wr_addr_i,
  input  logic [WORD_W-1:0]       wr_data_i,
  input  logic                    go_i,
  input  logic [AW-1:0]           rd_addr_i,
  output logic [WORD_W-1:0]       rd_data_o,
  output logic                    busy_o,
  output logic                    res_valid_o,
  output logic                    err_o,
  output logic                    start_o,
  output logic [PE_NB*WORD_W-1:0] a_o,
  output logic [WORD_W-1:0]       b_o,
  output logic [WORD_W-1:0]       p_o,
  input  logic                    a_shift_i,
  input  logic                    b_fetch_i,
  input  logic                    p_fetch_i,
  input  logic                    RES_push_i,
  input  logic                    done_i,
  input  logic [WORD_W-1:0]       RES_i
);
  localparam int KMAX = (s + PE_NB - 1) / PE_NB;
  localparam int KW   = $clog2(KMAX + 1);
  localparam int RW   = $clog2(s + 1);

  opsrv_state_t              r_state, w_state_nxt;
  logic [AW-1:0]             r_bptr, w_bptr_nxt, r_pptr, w_pptr_nxt;
  logic [KW-1:0]             r_k, w_k_nxt;
  logic [RW-1:0]             r_rptr, w_rptr_nxt;
  logic [WORD_W-1:0]         r_amem [s];
  logic [PE_NB*WORD_W-1:0]   r_a_win, w_win_nxt;
  logic                      w_run, w_host_ok, w_go, w_push_ok, w_a_ld;

  assign w_run     = (r_state == RUN);
  assign w_host_ok = (r_state == IDLE) || (r_state == DONE);
  assign w_go      = go_i && w_host_ok;
  assign w_a_ld    = w_go || (w_run && a_shift_i);

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) r_state <= IDLE;
    else            r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE, DONE: if (w_go)   w_state_nxt = START;
      START:                  w_state_nxt = RUN;
      RUN:        if (done_i) w_state_nxt = DONE;
      default:                w_state_nxt = IDLE;
    endcase
  end

`ifdef FIOS_OPSRV_PROTO_CHECK_EN
  // Result pointer stops at s so an overflowing push is dropped and flagged.
  assign w_push_ok = w_run && RES_push_i && (r_rptr != RW'(s));
`else
  assign w_push_ok = w_run && RES_push_i;
`endif

  always_comb begin
    w_bptr_nxt = r_bptr;
    w_pptr_nxt = r_pptr;
    w_k_nxt    = r_k;
    w_rptr_nxt = r_rptr;
    if (w_go) begin
      w_bptr_nxt = '0;
      w_pptr_nxt = '0;
      w_k_nxt    = '0;
      w_rptr_nxt = '0;
    end else if (w_run) begin
      if (b_fetch_i)
        w_bptr_nxt = (r_bptr == AW'(s - 1)) ? '0 : r_bptr + AW'(1);
      if (p_fetch_i)
        w_pptr_nxt = (r_pptr == AW'(s - 1)) ? '0 : r_pptr + AW'(1);
      if (a_shift_i && (r_k != KW'(KMAX)))
        w_k_nxt = r_k + KW'(1);
`ifdef FIOS_OPSRV_PROTO_CHECK_EN
      if (w_push_ok)
        w_rptr_nxt = r_rptr + RW'(1);
`else
      if (w_push_ok)
        w_rptr_nxt = (r_rptr == RW'(s - 1)) ? '0 : r_rptr + RW'(1);
`endif
    end
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_bptr  <= '0;
      r_pptr  <= '0;
      r_k     <= '0;
      r_rptr  <= '0;
      r_a_win <= '0;
    end else begin
      r_bptr <= w_bptr_nxt;
      r_pptr <= w_pptr_nxt;
      r_k    <= w_k_nxt;
      r_rptr <= w_rptr_nxt;
      if (w_a_ld) r_a_win <= w_win_nxt;
    end
  end

  always_ff @(posedge clock_i) begin
    if (wr_en_i && w_host_ok && (wr_sel_i == SEL_A)) r_amem[wr_addr_i] <= wr_data_i;
  end

  // Window words past the end of A read as zero.
  always_comb begin
    w_win_nxt = '0;
    for (int j = 0; j < PE_NB; j++) begin
      if (int'(w_k_nxt) * PE_NB + j < s)
        w_win_nxt[j*WORD_W +: WORD_W] = r_amem[AW'(int'(w_k_nxt) * PE_NB + j)];
    end
  end

  // B/P read the next pointer so the word tracks the pointer with one register.
  fios_opsrv_wbuf #(.s(s), .AW(AW)) u_bbuf (
    .i_clk     (clock_i),
    .i_rst_n   (reset_n_i),
    .i_wr_en   (wr_en_i && w_host_ok && (wr_sel_i == SEL_B)),
    .i_wr_addr (wr_addr_i),
    .i_wr_data (wr_data_i),
    .i_rd_en   (w_go || (w_run && b_fetch_i)),
    .i_rd_addr (w_bptr_nxt),
    .o_rd_data (b_o)
  );

  fios_opsrv_wbuf #(.s(s), .AW(AW)) u_pbuf (
    .i_clk     (clock_i),
    .i_rst_n   (reset_n_i),
    .i_wr_en   (wr_en_i && w_host_ok && (wr_sel_i == SEL_P)),
    .i_wr_addr (wr_addr_i),
    .i_wr_data (wr_data_i),
    .i_rd_en   (w_go || (w_run && p_fetch_i)),
    .i_rd_addr (w_pptr_nxt),
    .o_rd_data (p_o)
  );

  fios_opsrv_wbuf #(.s(s), .AW(AW)) u_rbuf (
    .i_clk     (clock_i),
    .i_rst_n   (reset_n_i),
    .i_wr_en   (w_push_ok),
    .i_wr_addr (r_rptr[AW-1:0]),
    .i_wr_data (RES_i),
    .i_rd_en   (1'b1),
    .i_rd_addr (rd_addr_i),
    .o_rd_data (rd_data_o)
  );

`ifdef FIOS_OPSRV_PROTO_CHECK_EN
  logic r_err, w_err_set;

  assign w_err_set = (w_run && RES_push_i && (r_rptr == RW'(s))) ||
                     (w_run && done_i && (w_rptr_nxt != RW'(s))) ||
                     (!w_run && (a_shift_i || b_fetch_i || p_fetch_i || RES_push_i || done_i));

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i)     r_err <= 1'b0;
    else if (w_go)      r_err <= 1'b0;
    else if (w_err_set) r_err <= 1'b1;
  end

  assign err_o = r_err;
`else
  assign err_o = 1'b0;
`endif

  assign a_o         = r_a_win;
  assign start_o     = (r_state == START);
  assign busy_o      = (r_state == START) || (r_state == RUN);
  assign res_valid_o = (r_state == DONE);
endmodule

// File: tb/tb_fios_operand_server.sv
// Directed bench for fios_operand_server (s=8, PE_NB=4).
module tb_fios_operand_server;
  localparam int S   = 8;
  localparam int PNB = 4;
  localparam int W   = 17;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           wr_en = 1'b0;
  logic [1:0]     wr_sel = '0;
  logic [2:0]     wr_addr = '0;
  logic [W-1:0]   wr_data = '0;
  logic           go = 1'b0;
  logic [2:0]     rd_addr = '0;
  logic [W-1:0]   rd_data;
  logic           busy, res_valid, err, start;
  logic [PNB*W-1:0] a_win;
  logic [W-1:0]   b_w, p_w;
  logic           a_shift = 1'b0, b_fetch = 1'b0, p_fetch = 1'b0, push = 1'b0, done = 1'b0;
  logic [W-1:0]   res = '0;

  int n_chk  = 0;
  int n_fail = 0;

  fios_operand_server #(.s(S), .PE_NB(PNB)) dut (
    .clock_i(clk), .reset_n_i(rst_n),
    .wr_en_i(wr_en), .wr_sel_i(wr_sel), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
    .go_i(go), .rd_addr_i(rd_addr), .rd_data_o(rd_data),
    .busy_o(busy), .res_valid_o(res_valid), .err_o(err), .start_o(start),
    .a_o(a_win), .b_o(b_w), .p_o(p_w),
    .a_shift_i(a_shift), .b_fetch_i(b_fetch), .p_fetch_i(p_fetch),
    .RES_push_i(push), .done_i(done), .RES_i(res)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_word(input logic [1:0] sel, input int addr, input logic [W-1:0] data);
    wr_en = 1'b1; wr_sel = sel; wr_addr = 3'(addr); wr_data = data;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic pulse_go();
    go = 1'b1;
    tick();
    go = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    n_chk++; if (busy !== 1'b0 || start !== 1'b0 || res_valid !== 1'b0 || err !== 1'b0) begin
      n_fail++; $display("FAIL reset_ctrl busy=%b start=%b rv=%b err=%b want 0000", busy, start, res_valid, err);
    end
    n_chk++; if (a_win !== '0 || b_w !== '0 || p_w !== '0 || rd_data !== '0) begin
      n_fail++; $display("FAIL reset_data a=%h b=%h p=%h rd=%h want 0", a_win, b_w, p_w, rd_data);
    end
    #10 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_b_stream();
    for (int i = 0; i < S; i++) wr_word(2'd1, i, W'(i + 1));
    for (int i = 0; i < S; i++) wr_word(2'd2, i, W'(32'h80 + i));
    pulse_go();
    n_chk++; if (start !== 1'b1 || busy !== 1'b1) begin
      n_fail++; $display("FAIL go_start start=%b busy=%b want 1 1", start, busy);
    end
    n_chk++; if (b_w !== 17'd1 || p_w !== 17'h80) begin
      n_fail++; $display("FAIL b_first b=%h p=%h want 1 80", b_w, p_w);
    end
    tick();
    n_chk++; if (start !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL start_pulse start=%b busy=%b want 0 1", start, busy);
    end
    for (int i = 0; i < S; i++) begin
      b_fetch = 1'b1; tick(); b_fetch = 1'b0;
      n_chk++; if (b_w !== W'(((i + 1) % S) + 1)) begin
        n_fail++; $display("FAIL b_stream[%0d] b=%h want %h", i, b_w, W'(((i + 1) % S) + 1));
      end
    end
    n_chk++; if (p_w !== 17'h80) begin
      n_fail++; $display("FAIL p_indep p=%h want 80", p_w);
    end
    b_fetch = 1'b1; p_fetch = 1'b1; tick(); b_fetch = 1'b0; p_fetch = 1'b0;
    n_chk++; if (b_w !== 17'd2 || p_w !== 17'h81) begin
      n_fail++; $display("FAIL bp_simul b=%h p=%h want 2 81", b_w, p_w);
    end
    p_fetch = 1'b1; tick(); p_fetch = 1'b0;
    n_chk++; if (b_w !== 17'd2 || p_w !== 17'h82) begin
      n_fail++; $display("FAIL p_only b=%h p=%h want 2 82", b_w, p_w);
    end
    done = 1'b1; tick(); done = 1'b0;
    n_chk++; if (busy !== 1'b0 || res_valid !== 1'b1) begin
      n_fail++; $display("FAIL done_state busy=%b rv=%b want 0 1", busy, res_valid);
    end
  endtask

  task automatic test_a_window();
    logic [PNB*W-1:0] exp;
    for (int i = 0; i < S; i++) wr_word(2'd0, i, W'(32'h100 + i));
    pulse_go();
    n_chk++; if (res_valid !== 1'b0) begin
      n_fail++; $display("FAIL go_clears_rv rv=%b want 0", res_valid);
    end
    for (int j = 0; j < PNB; j++) exp[j*W +: W] = W'(32'h100 + j);
    n_chk++; if (a_win !== exp) begin
      n_fail++; $display("FAIL a_win0 a=%h want %h", a_win, exp);
    end
    tick();
    a_shift = 1'b1; tick(); a_shift = 1'b0;
    for (int j = 0; j < PNB; j++) exp[j*W +: W] = W'(32'h104 + j);
    n_chk++; if (a_win !== exp) begin
      n_fail++; $display("FAIL a_win1 a=%h want %h", a_win, exp);
    end
    a_shift = 1'b1; tick(); a_shift = 1'b0;
    n_chk++; if (a_win !== '0) begin
      n_fail++; $display("FAIL a_win2 a=%h want 0", a_win);
    end
    a_shift = 1'b1; tick(); a_shift = 1'b0;
    n_chk++; if (a_win !== '0) begin
      n_fail++; $display("FAIL a_win_sat a=%h want 0", a_win);
    end
    done = 1'b1; tick(); done = 1'b0;
  endtask

  task automatic run_pushes(input int n);
    pulse_go();
    tick();
    for (int i = 0; i < n; i++) begin
      push = 1'b1; res = W'(32'h1FFFF - i);
      tick();
    end
    push = 1'b0;
    n_chk++; if (busy !== 1'b1 || res_valid !== 1'b0) begin
      n_fail++; $display("FAIL pre_done busy=%b rv=%b want 1 0", busy, res_valid);
    end
    done = 1'b1; tick(); done = 1'b0;
    n_chk++; if (res_valid !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL post_done rv=%b busy=%b want 1 0", res_valid, busy);
    end
  endtask

  task automatic test_results();
    run_pushes(8);
    n_chk++; if (err !== 1'b0) begin
      n_fail++; $display("FAIL res_err err=%b want 0", err);
    end
    rd_addr = 3'd3; tick();
    n_chk++; if (rd_data !== 17'h1FFFC) begin
      n_fail++; $display("FAIL rd3 rd=%h want 1fffc", rd_data);
    end
    rd_addr = 3'd7; tick();
    n_chk++; if (rd_data !== 17'h1FFF8) begin
      n_fail++; $display("FAIL rd7 rd=%h want 1fff8", rd_data);
    end
  endtask

  task automatic test_overflow();
    logic             exp_err;
    logic [W-1:0]     exp_r0;
`ifdef FIOS_OPSRV_PROTO_CHECK_EN
    exp_err = 1'b1; exp_r0 = 17'h1FFFF;
`else
    exp_err = 1'b0; exp_r0 = 17'h1FFF7;
`endif
    run_pushes(9);
    n_chk++; if (err !== exp_err) begin
      n_fail++; $display("FAIL ovf_err err=%b want %b", err, exp_err);
    end
    rd_addr = 3'd0; tick();
    n_chk++; if (rd_data !== exp_r0) begin
      n_fail++; $display("FAIL ovf_r0 rd=%h want %h", rd_data, exp_r0);
    end
    rd_addr = 3'd1; tick();
    n_chk++; if (rd_data !== 17'h1FFFE) begin
      n_fail++; $display("FAIL ovf_r1 rd=%h want 1fffe", rd_data);
    end
  endtask

  task automatic test_reset_midrun();
    pulse_go();
    n_chk++; if (err !== 1'b0) begin
      n_fail++; $display("FAIL go_clears_err err=%b want 0", err);
    end
    tick();
    for (int i = 0; i < 3; i++) begin
      b_fetch = 1'b1; tick(); b_fetch = 1'b0;
    end
    n_chk++; if (b_w !== 17'd4) begin
      n_fail++; $display("FAIL pre_rst b=%h want 4", b_w);
    end
    rst_n = 1'b0;
    #1;
    n_chk++; if (busy !== 1'b0 || start !== 1'b0 || res_valid !== 1'b0 || err !== 1'b0 ||
                 b_w !== '0 || p_w !== '0 || a_win !== '0 || rd_data !== '0) begin
      n_fail++; $display("FAIL async_rst busy=%b b=%h p=%h a=%h rd=%h want all 0", busy, b_w, p_w, a_win, rd_data);
    end
    #2 rst_n = 1'b1;
    tick();
    n_chk++; if (busy !== 1'b0 || start !== 1'b0) begin
      n_fail++; $display("FAIL post_rst busy=%b start=%b want 0 0", busy, start);
    end
    for (int i = 0; i < S; i++) wr_word(2'd1, i, W'(i + 1));
    wr_word(2'd1, 0, 17'h1ABCD);
    pulse_go();
    n_chk++; if (b_w !== 17'h1ABCD || start !== 1'b1) begin
      n_fail++; $display("FAIL restart b=%h start=%b want 1abcd 1", b_w, start);
    end
    tick();
    b_fetch = 1'b1; tick(); b_fetch = 1'b0;
    n_chk++; if (b_w !== 17'd2) begin
      n_fail++; $display("FAIL restart_fetch b=%h want 2", b_w);
    end
  endtask

  task automatic test_run_ignores();
    logic exp_err;
    // still in RUN from the restart, bptr = 1
    go = 1'b1; tick(); go = 1'b0;
    n_chk++; if (start !== 1'b0 || busy !== 1'b1 || b_w !== 17'd2) begin
      n_fail++; $display("FAIL go_in_run start=%b busy=%b b=%h want 0 1 2", start, busy, b_w);
    end
    wr_word(2'd1, 2, 17'h0AAAA);
    b_fetch = 1'b1; tick(); b_fetch = 1'b0;
    n_chk++; if (b_w !== 17'd3) begin
      n_fail++; $display("FAIL wr_in_run b=%h want 3", b_w);
    end
    done = 1'b1; tick(); done = 1'b0;
    b_fetch = 1'b1; tick(); b_fetch = 1'b0;
`ifdef FIOS_OPSRV_PROTO_CHECK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    n_chk++; if (b_w !== 17'd3 || err !== exp_err || res_valid !== 1'b1) begin
      n_fail++; $display("FAIL fetch_in_done b=%h err=%b rv=%b want 3 %b 1", b_w, err, res_valid, exp_err);
    end
  endtask

  initial begin
    test_reset();
    test_b_stream();
    test_a_window();
    test_results();
    test_overflow();
    test_reset_midrun();
    test_run_ignores();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
